// File: rtl/txrx_burst_sched.sv
// txrx_burst_sched: runs burst_num TX -> gap -> RX -> rest measurement cycles per start
// request, with abort, RX timeout detection and registered control outputs.
module txrx_burst_sched #(
  parameter int CNT_W    = 8,
  parameter int GAP_CYC  = 100,
  parameter int TMO_CYC  = 100000,
  parameter int REST_CYC = 1000,
  parameter int TMR_W    = 20
) (
  input  logic             clk_100,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] burst_num,
  input  logic             over_tx,
  input  logic             over_rx,
  output logic             en_tx,
  output logic             en_rx,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             rx_timeout,
  output logic [CNT_W-1:0] cycle_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_GAP,
    S_RX,
    S_REST,
    S_DONE
  } state_t;

  // Timer reload values: each timed state lasts exactly <N>_CYC cycles (N-1 down to 0).
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD  = TMR_W'(TMO_CYC - 1);
  localparam logic [TMR_W-1:0] REST_LOAD = TMR_W'(REST_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] n_nxt;
  logic [CNT_W-1:0] idx_nxt;
  logic             tmo_nxt;
  logic             abort_take;

  // Next-state logic; abort outranks every other event outside IDLE.
  always_comb begin
    state_nxt  = state;
    tmr_nxt    = tmr;
    n_nxt      = n_lat;
    idx_nxt    = cycle_idx;
    tmo_nxt    = rx_timeout;
    abort_take = 1'b0;
    if (state != S_IDLE && abort) begin
      state_nxt  = S_IDLE;
      abort_take = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_TX;
            n_nxt     = (burst_num == '0) ? CNT_W'(1) : burst_num;
            idx_nxt   = '0;
            tmo_nxt   = 1'b0;
          end
        end
        S_TX: begin
          if (over_tx) begin
            state_nxt = S_GAP;
            tmr_nxt   = GAP_LOAD;
          end
        end
        S_GAP: begin
          if (tmr == '0) begin
            state_nxt = S_RX;
            tmr_nxt   = TMO_LOAD;
          end else begin
            tmr_nxt = tmr - TMR_W'(1);
          end
        end
        S_RX: begin
          // A completion on the last window cycle still counts as a normal finish.
          if (over_rx) begin
            state_nxt = S_REST;
            tmr_nxt   = REST_LOAD;
          end else if (tmr == '0) begin
            state_nxt = S_REST;
            tmr_nxt   = REST_LOAD;
            tmo_nxt   = 1'b1;
          end else begin
            tmr_nxt = tmr - TMR_W'(1);
          end
        end
        S_REST: begin
          if (tmr == '0) begin
            if (cycle_idx == n_lat - CNT_W'(1)) begin
              state_nxt = S_DONE;
            end else begin
              state_nxt = S_TX;
              idx_nxt   = cycle_idx + CNT_W'(1);
            end
          end else begin
            tmr_nxt = tmr - TMR_W'(1);
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state      <= S_IDLE;
      tmr        <= '0;
      n_lat      <= '0;
      cycle_idx  <= '0;
      rx_timeout <= 1'b0;
      en_tx      <= 1'b0;
      en_rx      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmr        <= tmr_nxt;
      n_lat      <= n_nxt;
      cycle_idx  <= idx_nxt;
      rx_timeout <= tmo_nxt;
      en_tx      <= (state_nxt == S_TX);
      en_rx      <= (state_nxt == S_RX);
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_DONE);
      aborted    <= abort_take;
    end
  end

endmodule

// File: tb/tb_txrx_burst_sched.sv
// Directed bench for txrx_burst_sched with GAP=4, TMO=16, REST=3.
module tb_txrx_burst_sched;

  logic       clk_100 = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] burst_num;
  logic       over_tx;
  logic       over_rx;
  logic       en_tx;
  logic       en_rx;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       rx_timeout;
  logic [7:0] cycle_idx;

  int n_tests = 0;
  int n_fail  = 0;

  txrx_burst_sched #(
    .CNT_W(8), .GAP_CYC(4), .TMO_CYC(16), .REST_CYC(3), .TMR_W(8)
  ) dut (
    .clk_100(clk_100), .rst(rst), .start(start), .abort(abort), .burst_num(burst_num),
    .over_tx(over_tx), .over_rx(over_rx), .en_tx(en_tx), .en_rx(en_rx), .busy(busy),
    .done(done), .aborted(aborted), .rx_timeout(rx_timeout), .cycle_idx(cycle_idx)
  );

  always #5 clk_100 = ~clk_100;

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_rx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (en_rx) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // From an observed en_tx=1: answer TX after tx_lat cycles, measure the dead time,
  // answer RX after rx_lat cycles; returns having just entered REST.
  task automatic run_to_rest(input int tx_lat, input int rx_lat, output int gap_cnt);
    repeat (tx_lat - 1) step();
    over_tx = 1'b1;
    step();
    over_tx = 1'b0;
    gap_cnt = 0;
    while (!en_rx && gap_cnt < 64) begin
      gap_cnt++;
      step();
    end
    repeat (rx_lat - 1) step();
    over_rx = 1'b1;
    step();
    over_rx = 1'b0;
  endtask

  // Counts idle cycles until the next TX or the done pulse.
  task automatic count_rest(output int rest_cnt);
    rest_cnt = 0;
    while (!en_tx && !done && rest_cnt < 64) begin
      rest_cnt++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({en_tx, en_rx, busy, done, aborted, rx_timeout, cycle_idx} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_init outputs=%b exp all zero",
               {en_tx, en_rx, busy, done, aborted, rx_timeout, cycle_idx});
    end
    rst = 1'b0;
    burst_num = 8'd2;
    pulse_start();
    begin
      int g, r;
      run_to_rest(2, 2, g);
      count_rest(r);
    end
    n_tests++;
    if (en_tx !== 1'b1 || cycle_idx !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_setup en_tx=%b cycle_idx=%0d exp 1/1", en_tx, cycle_idx);
    end
    rst = 1'b1;
    step();
    n_tests++;
    if (en_tx !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cycle_idx !== 8'd0 || aborted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid en_tx=%b busy=%b done=%b aborted=%b cycle_idx=%0d exp 0",
               en_tx, busy, done, aborted, cycle_idx);
    end
    repeat (2) step();
    rst = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0 || en_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release busy=%b en_tx=%b exp 0", busy, en_tx);
    end
  endtask

  task automatic test_burst2();
    int g, r, dones;
    burst_num = 8'd2;
    pulse_start();
    n_tests++;
    if (en_tx !== 1'b1 || busy !== 1'b1 || cycle_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL b2_start en_tx=%b busy=%b cycle_idx=%0d exp 1/1/0", en_tx, busy, cycle_idx);
    end
    run_to_rest(5, 10, g);
    n_tests++;
    if (g !== 4) begin
      n_fail++;
      $display("FAIL b2_gap0 gap=%0d exp 4", g);
    end
    count_rest(r);
    n_tests++;
    if (r !== 3 || en_tx !== 1'b1 || cycle_idx !== 8'd1) begin
      n_fail++;
      $display("FAIL b2_rest0 rest=%0d en_tx=%b cycle_idx=%0d exp 3/1/1", r, en_tx, cycle_idx);
    end
    run_to_rest(5, 10, g);
    n_tests++;
    if (g !== 4) begin
      n_fail++;
      $display("FAIL b2_gap1 gap=%0d exp 4", g);
    end
    count_rest(r);
    n_tests++;
    if (r !== 3 || done !== 1'b1 || busy !== 1'b1 || cycle_idx !== 8'd1) begin
      n_fail++;
      $display("FAIL b2_done rest=%0d done=%b busy=%b cycle_idx=%0d exp 3/1/1/1", r, done, busy, cycle_idx);
    end
    dones = 0;
    repeat (5) begin
      step();
      if (done) dones++;
    end
    n_tests++;
    if (dones !== 0 || busy !== 1'b0 || en_tx !== 1'b0 || cycle_idx !== 8'd1) begin
      n_fail++;
      $display("FAIL b2_after extra_done=%0d busy=%b en_tx=%b cycle_idx=%0d exp 0/0/0/1",
               dones, busy, en_tx, cycle_idx);
    end
  endtask

  task automatic test_timeout();
    int hi, r;
    bit ok;
    burst_num = 8'd0;
    pulse_start();
    repeat (2) step();
    over_tx = 1'b1;
    step();
    over_tx = 1'b0;
    wait_rx(ok);
    hi = 0;
    while (en_rx && hi < 64) begin
      hi++;
      step();
    end
    n_tests++;
    if (!ok || hi !== 16 || rx_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_window seen=%0b en_rx_cycles=%0d rx_timeout=%b exp 1/16/1", ok, hi, rx_timeout);
    end
    count_rest(r);
    n_tests++;
    if (r !== 3 || done !== 1'b1 || cycle_idx !== 8'd0 || rx_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_done rest=%0d done=%b cycle_idx=%0d rx_timeout=%b exp 3/1/0/1",
               r, done, cycle_idx, rx_timeout);
    end
    step();
  endtask

  task automatic test_rx_last_cycle();
    int r;
    bit ok;
    burst_num = 8'd1;
    pulse_start();
    n_tests++;
    if (rx_timeout !== 1'b0 || en_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL last_clear rx_timeout=%b en_tx=%b exp 0/1", rx_timeout, en_tx);
    end
    over_tx = 1'b1;
    step();
    over_tx = 1'b0;
    wait_rx(ok);
    repeat (15) step();
    n_tests++;
    if (!ok || en_rx !== 1'b1) begin
      n_fail++;
      $display("FAIL last_window seen=%0b en_rx=%b exp 1/1", ok, en_rx);
    end
    over_rx = 1'b1;
    step();
    over_rx = 1'b0;
    n_tests++;
    if (en_rx !== 1'b0 || rx_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL last_overrx en_rx=%b rx_timeout=%b exp 0/0", en_rx, rx_timeout);
    end
    count_rest(r);
    n_tests++;
    if (done !== 1'b1 || rx_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL last_done done=%b rx_timeout=%b exp 1/0", done, rx_timeout);
    end
    step();
  endtask

  task automatic test_abort();
    int hi, r, bad;
    bit ok;
    burst_num = 8'd2;
    pulse_start();
    over_tx = 1'b1;
    step();
    over_tx = 1'b0;
    wait_rx(ok);
    hi = 0;
    while (en_rx && hi < 64) begin
      hi++;
      step();
    end
    count_rest(r);
    n_tests++;
    if (en_tx !== 1'b1 || rx_timeout !== 1'b1 || cycle_idx !== 8'd1) begin
      n_fail++;
      $display("FAIL abort_setup en_tx=%b rx_timeout=%b cycle_idx=%0d exp 1/1/1", en_tx, rx_timeout, cycle_idx);
    end
    abort = 1'b1;
    over_tx = 1'b1;
    step();
    abort = 1'b0;
    over_tx = 1'b0;
    n_tests++;
    if (aborted !== 1'b1 || en_tx !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_tx aborted=%b en_tx=%b busy=%b done=%b exp 1/0/0/0", aborted, en_tx, busy, done);
    end
    bad = 0;
    repeat (8) begin
      step();
      if (en_rx || done || aborted || busy) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet bad_cycles=%0d exp 0", bad);
    end
    pulse_start();
    n_tests++;
    if (en_tx !== 1'b1 || rx_timeout !== 1'b0 || cycle_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_restart en_tx=%b rx_timeout=%b cycle_idx=%0d exp 1/0/0", en_tx, rx_timeout, cycle_idx);
    end
    abort = 1'b1;
    step();
    n_tests++;
    if (aborted !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_again aborted=%b busy=%b exp 1/0", aborted, busy);
    end
    bad = 0;
    repeat (3) begin
      step();
      if (aborted || busy) bad++;
    end
    abort = 1'b0;
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL abort_idle bad_cycles=%0d exp 0", bad);
    end
  endtask

  task automatic test_ignored_inputs();
    int g, r, bad;
    bit ok;
    burst_num = 8'd1;
    over_tx = 1'b1;
    over_rx = 1'b1;
    repeat (2) step();
    over_tx = 1'b0;
    over_rx = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || en_tx !== 1'b0 || en_rx !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_idle busy=%b en_tx=%b en_rx=%b exp 0", busy, en_tx, en_rx);
    end
    pulse_start();
    burst_num = 8'd5;
    pulse_start();
    n_tests++;
    if (en_tx !== 1'b1 || cycle_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL ign_start_tx en_tx=%b cycle_idx=%0d exp 1/0", en_tx, cycle_idx);
    end
    over_tx = 1'b1;
    step();
    over_tx = 1'b0;
    g = 1;
    over_tx = 1'b1;
    start = 1'b1;
    over_rx = 1'b0;
    step();
    over_tx = 1'b0;
    start = 1'b0;
    while (!en_rx && g < 64) begin
      g++;
      step();
    end
    n_tests++;
    if (g !== 4 || en_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_gap gap=%0d en_tx=%b exp 4/0", g, en_tx);
    end
    wait_rx(ok);
    over_rx = 1'b1;
    step();
    over_rx = 1'b0;
    count_rest(r);
    n_tests++;
    if (done !== 1'b1 || cycle_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL ign_done done=%b cycle_idx=%0d exp 1/0 (latched count must stay 1)", done, cycle_idx);
    end
    bad = 0;
    repeat (6) begin
      step();
      if (busy || en_tx) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL ign_no_queue bad_cycles=%0d exp 0", bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    burst_num = 8'd0;
    over_tx = 1'b0;
    over_rx = 1'b0;
    test_reset();
    test_burst2();
    test_timeout();
    test_rx_last_cycle();
    test_abort();
    test_ignored_inputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
